// File: rtl/lsb_queue.sv
// Load/store buffer: circular in-order queue of memory ops with CDB wake-up,
// head-only issue to the memory controller and result broadcast on the CDB.
module lsb_queue #(
  parameter int unsigned LSB_SIZE_BIT = 3,
  parameter int unsigned ROB_SIZE_BIT = 4,
  parameter logic [31:0] IO_ADDR_HI   = 32'h00030000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  output logic                    lsb_full,
  input  logic                    inst_input,
  input  logic [3:0]              lsb_op,
  input  logic [31:0]             lsb_imm,
  input  logic [31:0]             lsb_r1_val,
  input  logic [31:0]             lsb_r2_val,
  input  logic                    lsb_r1_has_dep,
  input  logic                    lsb_r2_has_dep,
  input  logic [ROB_SIZE_BIT-1:0] lsb_r1_dep,
  input  logic [ROB_SIZE_BIT-1:0] lsb_r2_dep,
  input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id_in,
  input  logic [ROB_SIZE_BIT-1:0] rob_head_id,
  input  logic                    alu_fi,
  input  logic [31:0]             alu_value,
  input  logic [ROB_SIZE_BIT-1:0] alu_rob_id,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [1:0]              mem_size,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_done,
  input  logic [31:0]             mem_rdata,
  output logic                    lsb_fi,
  output logic [31:0]             lsb_value,
  output logic [ROB_SIZE_BIT-1:0] lsb_rob_id
);

  localparam int unsigned DEPTH = 1 << LSB_SIZE_BIT;
  localparam int unsigned CNT_W = LSB_SIZE_BIT + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  typedef struct packed {
    logic                    valid;
    logic [3:0]              op;
    logic [31:0]             imm;
    logic [31:0]             r1_val;
    logic [31:0]             r2_val;
    logic                    r1_has_dep;
    logic                    r2_has_dep;
    logic [ROB_SIZE_BIT-1:0] r1_dep;
    logic [ROB_SIZE_BIT-1:0] r2_dep;
    logic [ROB_SIZE_BIT-1:0] rob_id;
  } entry_t;

  entry_t                  entries [DEPTH];
  state_t                  state_q, state_d;
  logic [LSB_SIZE_BIT-1:0] head_q, tail_q;
  logic [CNT_W-1:0]        count_q, count_d;
  entry_t                  head_e, new_e;
  logic [31:0]             head_addr;
  logic                    head_ready;
  logic                    enq, deq;
  logic                    req_d, we_d, fi_d;
  logic [1:0]              size_d;
  logic [31:0]             addr_d, wdata_d, value_d;
  logic [ROB_SIZE_BIT-1:0] id_d;

  // Sign/zero extension of raw load data by access size
  function automatic logic [31:0] extend(input logic [3:0] op, input logic [31:0] d);
    case (op[1:0])
      2'd0:    extend = op[2] ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'd1:    extend = op[2] ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // Head readiness: operands present; stores and IO loads wait for ROB head
  always_comb begin
    head_e     = entries[head_q];
    head_addr  = head_e.r1_val + head_e.imm;
    head_ready = head_e.valid && !head_e.r1_has_dep && !head_e.r2_has_dep &&
                 (!(head_e.op[3] || head_addr >= IO_ADDR_HI) || rob_head_id == head_e.rob_id);
  end

  // New entry with same-cycle CDB bypass on pending operands
  always_comb begin
    new_e            = '0;
    new_e.valid      = 1'b1;
    new_e.op         = lsb_op;
    new_e.imm        = lsb_imm;
    new_e.rob_id     = lsb_rob_id_in;
    new_e.r1_val     = lsb_r1_val;
    new_e.r1_has_dep = lsb_r1_has_dep;
    new_e.r1_dep     = lsb_r1_dep;
    new_e.r2_val     = lsb_r2_val;
    new_e.r2_has_dep = lsb_r2_has_dep;
    new_e.r2_dep     = lsb_r2_dep;
    if (lsb_r1_has_dep) begin
      if (alu_fi && alu_rob_id == lsb_r1_dep) begin
        new_e.r1_val = alu_value; new_e.r1_has_dep = 1'b0;
      end else if (lsb_fi && lsb_rob_id == lsb_r1_dep) begin
        new_e.r1_val = lsb_value; new_e.r1_has_dep = 1'b0;
      end
    end
    if (lsb_r2_has_dep) begin
      if (alu_fi && alu_rob_id == lsb_r2_dep) begin
        new_e.r2_val = alu_value; new_e.r2_has_dep = 1'b0;
      end else if (lsb_fi && lsb_rob_id == lsb_r2_dep) begin
        new_e.r2_val = lsb_value; new_e.r2_has_dep = 1'b0;
      end
    end
  end

  // Next-state, next-output and queue-pointer control
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    we_d    = mem_we;
    size_d  = mem_size;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    fi_d    = 1'b0;
    value_d = lsb_value;
    id_d    = lsb_rob_id;
    deq     = 1'b0;
    enq     = inst_input && !rob_clear && (count_q != CNT_W'(DEPTH));
    case (state_q)
      IDLE: begin
        if (!rob_clear && head_ready) begin
          req_d   = 1'b1;
          we_d    = head_e.op[3];
          size_d  = head_e.op[1:0];
          addr_d  = head_addr;
          wdata_d = head_e.r2_val;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_done) begin
          // A completion landing in the flush cycle is simply dropped
          if (!rob_clear) begin
            fi_d    = 1'b1;
            value_d = head_e.op[3] ? 32'h0 : extend(head_e.op, mem_rdata);
            id_d    = head_e.rob_id;
            deq     = 1'b1;
          end
          state_d = IDLE;
        end else if (rob_clear) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rob_clear) begin
      count_d = '0;
    end else begin
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in)      state_q <= IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  // Registered outputs and queue pointers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      lsb_full   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_size   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lsb_fi     <= 1'b0;
      lsb_value  <= '0;
      lsb_rob_id <= '0;
    end else if (rdy_in) begin
      count_q    <= count_d;
      lsb_full   <= (count_d >= CNT_W'(DEPTH - 1));
      mem_req    <= req_d;
      mem_we     <= we_d;
      mem_size   <= size_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      lsb_fi     <= fi_d;
      lsb_value  <= value_d;
      lsb_rob_id <= id_d;
      if (rob_clear) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (deq) head_q <= head_q + LSB_SIZE_BIT'(1);
        if (enq) tail_q <= tail_q + LSB_SIZE_BIT'(1);
      end
    end
  end

  // Entry storage: wake-up, dequeue, enqueue, flush
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries[LSB_SIZE_BIT'(i)] <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        for (int unsigned i = 0; i < DEPTH; i++) entries[LSB_SIZE_BIT'(i)].valid <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (entries[LSB_SIZE_BIT'(i)].valid) begin
            if (entries[LSB_SIZE_BIT'(i)].r1_has_dep) begin
              if (alu_fi && alu_rob_id == entries[LSB_SIZE_BIT'(i)].r1_dep) begin
                entries[LSB_SIZE_BIT'(i)].r1_val     <= alu_value;
                entries[LSB_SIZE_BIT'(i)].r1_has_dep <= 1'b0;
              end else if (lsb_fi && lsb_rob_id == entries[LSB_SIZE_BIT'(i)].r1_dep) begin
                entries[LSB_SIZE_BIT'(i)].r1_val     <= lsb_value;
                entries[LSB_SIZE_BIT'(i)].r1_has_dep <= 1'b0;
              end
            end
            if (entries[LSB_SIZE_BIT'(i)].r2_has_dep) begin
              if (alu_fi && alu_rob_id == entries[LSB_SIZE_BIT'(i)].r2_dep) begin
                entries[LSB_SIZE_BIT'(i)].r2_val     <= alu_value;
                entries[LSB_SIZE_BIT'(i)].r2_has_dep <= 1'b0;
              end else if (lsb_fi && lsb_rob_id == entries[LSB_SIZE_BIT'(i)].r2_dep) begin
                entries[LSB_SIZE_BIT'(i)].r2_val     <= lsb_value;
                entries[LSB_SIZE_BIT'(i)].r2_has_dep <= 1'b0;
              end
            end
          end
        end
        if (deq) entries[head_q].valid <= 1'b0;
        if (enq) entries[tail_q] <= new_e;
      end
    end
  end

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: vector table of loads plus store, IO,
// full/wrap and flush sequences.
module tb_lsb_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, lsb_full, inst_input;
  logic [3:0]  lsb_op;
  logic [31:0] lsb_imm, lsb_r1_val, lsb_r2_val;
  logic        lsb_r1_has_dep, lsb_r2_has_dep;
  logic [3:0]  lsb_r1_dep, lsb_r2_dep, lsb_rob_id_in, rob_head_id;
  logic        alu_fi;
  logic [31:0] alu_value;
  logic [3:0]  alu_rob_id;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        lsb_fi;
  logic [31:0] lsb_value;
  logic [3:0]  lsb_rob_id;

  int checks = 0;
  int errors = 0;

  lsb_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .lsb_full(lsb_full), .inst_input(inst_input), .lsb_op(lsb_op), .lsb_imm(lsb_imm),
    .lsb_r1_val(lsb_r1_val), .lsb_r2_val(lsb_r2_val),
    .lsb_r1_has_dep(lsb_r1_has_dep), .lsb_r2_has_dep(lsb_r2_has_dep),
    .lsb_r1_dep(lsb_r1_dep), .lsb_r2_dep(lsb_r2_dep), .lsb_rob_id_in(lsb_rob_id_in),
    .rob_head_id(rob_head_id), .alu_fi(alu_fi), .alu_value(alu_value),
    .alu_rob_id(alu_rob_id), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .lsb_fi(lsb_fi), .lsb_value(lsb_value), .lsb_rob_id(lsb_rob_id)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] r1;
    logic [31:0] imm;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] value;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic enq(input logic [3:0] op, input logic [31:0] imm, input logic [31:0] r1,
                     input logic [31:0] r2, input logic r1h, input logic [3:0] r1d,
                     input logic r2h, input logic [3:0] r2d, input logic [3:0] tag);
    inst_input = 1'b1; lsb_op = op; lsb_imm = imm; lsb_r1_val = r1; lsb_r2_val = r2;
    lsb_r1_has_dep = r1h; lsb_r1_dep = r1d; lsb_r2_has_dep = r2h; lsb_r2_dep = r2d;
    lsb_rob_id_in = tag;
    @(negedge clk_in);
    inst_input = 1'b0; lsb_r1_has_dep = 1'b0; lsb_r2_has_dep = 1'b0;
  endtask

  // Bounded wait for a memory request; expiry counts as a failed check
  task automatic wait_req(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (mem_req) begin found = 1'b1; break; end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s: got no mem_req expected mem_req within 20 cycles", name);
    end
  endtask

  // Answer the outstanding request and check the CDB pulse
  task automatic complete(input string name, input logic [31:0] rdata,
                          input logic [31:0] exp_val, input logic [3:0] exp_tag);
    mem_done = 1'b1; mem_rdata = rdata;
    @(negedge clk_in);
    mem_done = 1'b0;
    check({name, " req_one_cycle"}, 32'(mem_req), 32'd0);
    check({name, " fi"}, 32'(lsb_fi), 32'd1);
    check({name, " value"}, lsb_value, exp_val);
    check({name, " tag"}, 32'(lsb_rob_id), 32'(exp_tag));
    @(negedge clk_in);
    check({name, " fi_pulse"}, 32'(lsb_fi), 32'd0);
  endtask

  initial begin
    vecs[0] = '{4'b0010, 32'h100,  32'h4,        32'hDEADBEEF, 32'h104,  2'd2, 32'hDEADBEEF};
    vecs[1] = '{4'b0000, 32'h200,  32'h1,        32'h00000080, 32'h201,  2'd0, 32'hFFFFFF80};
    vecs[2] = '{4'b0100, 32'h200,  32'h2,        32'h00000080, 32'h202,  2'd0, 32'h00000080};
    vecs[3] = '{4'b0001, 32'h300,  32'h0,        32'h00008001, 32'h300,  2'd1, 32'hFFFF8001};
    vecs[4] = '{4'b0101, 32'h300,  32'h2,        32'h00008001, 32'h302,  2'd1, 32'h00008001};
    vecs[5] = '{4'b0010, 32'h1000, 32'hFFFFFFFC, 32'h7FFFFFFF, 32'hFFC,  2'd2, 32'h7FFFFFFF};
    vecs[6] = '{4'b0000, 32'h10,   32'h10,       32'h0000007F, 32'h20,   2'd0, 32'h0000007F};

    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; inst_input = 1'b0;
    lsb_op = '0; lsb_imm = '0; lsb_r1_val = '0; lsb_r2_val = '0;
    lsb_r1_has_dep = 1'b0; lsb_r2_has_dep = 1'b0; lsb_r1_dep = '0; lsb_r2_dep = '0;
    lsb_rob_id_in = '0; rob_head_id = 4'd15; alu_fi = 1'b0; alu_value = '0;
    alu_rob_id = '0; mem_done = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset lsb_fi", 32'(lsb_fi), 32'd0);
    check("reset lsb_full", 32'(lsb_full), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset lsb_value", lsb_value, 32'd0);

    // Speculative loads of every size/sign
    for (int i = 0; i < 7; i++) begin
      enq(vecs[i].op, vecs[i].imm, vecs[i].r1, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'(i));
      wait_req($sformatf("vec%0d req", i));
      check($sformatf("vec%0d addr", i), mem_addr, vecs[i].addr);
      check($sformatf("vec%0d size", i), 32'(mem_size), 32'(vecs[i].size));
      check($sformatf("vec%0d we", i), 32'(mem_we), 32'd0);
      complete($sformatf("vec%0d", i), vecs[i].rdata, vecs[i].value, 4'(i));
    end

    // Store waits for its data dependency and for ROB head
    rob_head_id = 4'd2;
    enq(4'b1010, 32'h0, 32'h40, 32'h0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd7);
    alu_fi = 1'b1; alu_rob_id = 4'd5; alu_value = 32'h12;
    @(negedge clk_in);
    alu_fi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check($sformatf("store hold%0d", i), 32'(mem_req), 32'd0);
    end
    rob_head_id = 4'd7;
    wait_req("store req");
    check("store we", 32'(mem_we), 32'd1);
    check("store wdata", mem_wdata, 32'h12);
    check("store addr", mem_addr, 32'h40);
    complete("store", 32'h0, 32'h0, 4'd7);

    // IO-space load with base bypassed from the ALU in the enqueue cycle
    rob_head_id = 4'd1;
    alu_fi = 1'b1; alu_rob_id = 4'd9; alu_value = 32'h00030000;
    enq(4'b0010, 32'h0, 32'h0, 32'h0, 1'b1, 4'd9, 1'b0, 4'd0, 4'd10);
    alu_fi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check($sformatf("io hold%0d", i), 32'(mem_req), 32'd0);
    end
    rob_head_id = 4'd10;
    wait_req("io req");
    check("io addr", mem_addr, 32'h00030000);
    complete("io", 32'h55, 32'h55, 4'd10);

    // Fill to DEPTH-1, free one slot, refill, then drain in FIFO order across the wrap
    rob_head_id = 4'd15;
    for (int k = 0; k < 7; k++) begin
      enq(4'b1010, 32'(4 * k), 32'h1000, 32'(k), 1'b0, 4'd0, 1'b0, 4'd0, 4'(k));
      check($sformatf("full after %0d", k + 1), 32'(lsb_full), (k == 6) ? 32'd1 : 32'd0);
    end
    rob_head_id = 4'd0;
    wait_req("fill req0");
    check("fill addr0", mem_addr, 32'h1000);
    complete("fill0", 32'h0, 32'h0, 4'd0);
    check("full after deq", 32'(lsb_full), 32'd0);
    enq(4'b1010, 32'(28), 32'h1000, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
    check("full after refill", 32'(lsb_full), 32'd1);
    for (int k = 1; k < 8; k++) begin
      rob_head_id = 4'(k);
      wait_req($sformatf("fill req%0d", k));
      check($sformatf("fill addr%0d", k), mem_addr, 32'h1000 + 32'(4 * k));
      check($sformatf("fill wdata%0d", k), mem_wdata, 32'(k));
      complete($sformatf("fill%0d", k), 32'h0, 32'h0, 4'(k));
    end
    check("empty not full", 32'(lsb_full), 32'd0);

    // Flush during a busy load; enqueue in the flush cycle is dropped
    rob_head_id = 4'd15;
    enq(4'b0010, 32'h0, 32'h500, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    wait_req("clear req");
    rob_clear = 1'b1;
    enq(4'b0010, 32'h0, 32'h600, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
    rob_clear = 1'b0;
    check("clear full", 32'(lsb_full), 32'd0);
    check("clear no req", 32'(mem_req), 32'd0);
    repeat (2) @(negedge clk_in);
    mem_done = 1'b1; mem_rdata = 32'h1234;
    @(negedge clk_in);
    mem_done = 1'b0;
    check("drain no fi", 32'(lsb_fi), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check($sformatf("clear idle req%0d", i), 32'(mem_req), 32'd0);
      check($sformatf("clear idle fi%0d", i), 32'(lsb_fi), 32'd0);
    end
    enq(4'b0010, 32'h8, 32'h300, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
    wait_req("post clear req");
    check("post clear addr", mem_addr, 32'h308);
    complete("post clear", 32'hCAFE0000, 32'hCAFE0000, 4'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
